vga_scan_out: RTL and testbench

- Display-side consumer of the 640x480x24-bit frame memory.
- Generates 640x480@60 Hz VGA timing and drives the memory's read address (raddr_h/raddr_v).
- Samples the returned 24-bit pixel and emits registered RGB888, hsync, vsync, data-enable and a frame-start pulse to the DAC/HDMI encoder.
- The frame memory read path is combinational, so address and data belong to the same pixel tick.

---
 rtl/vga_pkg.sv | 56 +++++
 rtl/vga_timing_cnt.sv | 70 +++++++
 rtl/vga_scan_out.sv | 111 +++++++++++
 tb/tb_vga_scan_out.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, widths and types for the VGA scan-out path.
// The phase helper lets the horizontal and vertical FSMs share one rule set.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    localparam int CNT_W    = 10;
    localparam int CNT_MAX  = 1 << CNT_W;
    localparam int RGB_W    = 8;
    localparam int ADDR_H_W = 10;
    localparam int ADDR_V_W = 9;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FPCH = 2'd1,
        PH_SYN  = 2'd2,
        PH_BPCH = 2'd3
    } phase_e;

    // Phase that holds after the counter advances past cnt.
    function automatic phase_e phase_next(input phase_e ph, input logic [CNT_W-1:0] cnt,
                                          input int active, input int fp,
                                          input int sync, input int total);
        phase_e nxt;
        nxt = ph;
        case (ph)
            PH_ACT:  if (cnt == CNT_W'(active - 1))               nxt = PH_FPCH;
            PH_FPCH: if (cnt == CNT_W'(active + fp - 1))          nxt = PH_SYN;
            PH_SYN:  if (cnt == CNT_W'(active + fp + sync - 1))   nxt = PH_BPCH;
            PH_BPCH: if (cnt == CNT_W'(total - 1))                nxt = PH_ACT;
            default: nxt = PH_ACT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// Pixel/line counters with wrap logic and the horizontal/vertical phase FSMs.
// Outputs are decoded from the current counter position (no added latency).
module vga_timing_cnt
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pix_ce,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_active,
    output logic             o_hsync_raw,
    output logic             o_vsync_raw,
    output logic             o_sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    phase_e           r_h_ph;
    phase_e           r_v_ph;
    phase_e           w_h_ph_nxt;
    phase_e           w_v_ph_nxt;
    logic             w_h_wrap;
    logic             w_v_wrap;

    assign w_h_wrap = (r_h_cnt == CNT_W'(H_TOTAL - 1));
    assign w_v_wrap = (r_v_cnt == CNT_W'(V_TOTAL - 1));

    // NOTE: synchronous reset; every register here is a flop, so all of them get a reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_h_ph  <= PH_ACT;
            r_v_ph  <= PH_ACT;
        end else if (i_pix_ce) begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
            r_h_ph  <= w_h_ph_nxt;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
                r_v_ph  <= w_v_ph_nxt;
            end
        end
    end

    always_comb begin
        w_h_ph_nxt = phase_next(r_h_ph, r_h_cnt, H_ACTIVE, H_FP, H_SYNC, H_TOTAL);
        w_v_ph_nxt = phase_next(r_v_ph, r_v_cnt, V_ACTIVE, V_FP, V_SYNC, V_TOTAL);
    end

    assign o_h_cnt     = r_h_cnt;
    assign o_v_cnt     = r_v_cnt;
    assign o_active    = (r_h_ph == PH_ACT) && (r_v_ph == PH_ACT);
    assign o_hsync_raw = (r_h_ph == PH_SYN);
    assign o_vsync_raw = (r_v_ph == PH_SYN);
    assign o_sof       = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out: drives frame-memory read address from the timing counters and
// registers the returned pixel plus syncs one pixel tick later.
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_ce_i,
    output logic [ADDR_H_W-1:0] raddr_h_o,
    output logic [ADDR_V_W-1:0] raddr_v_o,
    input  logic [3*RGB_W-1:0]  vga_rdata_i,
    output logic [RGB_W-1:0]    vga_r_o,
    output logic [RGB_W-1:0]    vga_g_o,
    output logic [RGB_W-1:0]    vga_b_o,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                de_o,
    output logic                frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_total_err
        $error("vga_scan_out: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end
    if (H_ACTIVE > (1 << ADDR_H_W) || V_ACTIVE > (1 << ADDR_V_W)) begin : g_addr_err
        $error("vga_scan_out: active area exceeds the read-address range");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_phase_err
        $error("vga_scan_out: every timing phase must be at least one unit long");
    end

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_active;
    logic             w_hsync_raw;
    logic             w_vsync_raw;
    logic             w_sof;

    pixel_t r_pix;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_de;
    logic   r_frame_start;

    vga_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pix_ce    (pix_ce_i),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_active    (w_active),
        .o_hsync_raw (w_hsync_raw),
        .o_vsync_raw (w_vsync_raw),
        .o_sof       (w_sof)
    );

    // Address is parked at (0,0) in blanking so it never leaves the 640x480 memory.
    assign raddr_h_o = w_active ? w_h_cnt[ADDR_H_W-1:0] : '0;
    assign raddr_v_o = w_active ? w_v_cnt[ADDR_V_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix         <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Cleared on every clk so the pulse lasts one clk even at reduced pixel rate.
            r_frame_start <= 1'b0;
            if (pix_ce_i) begin
                r_pix         <= w_active ? pixel_t'(vga_rdata_i) : '0;
                r_hsync       <= w_hsync_raw ? SYNC_POL : ~SYNC_POL;
                r_vsync       <= w_vsync_raw ? SYNC_POL : ~SYNC_POL;
                r_de          <= w_active;
                r_frame_start <= w_sof;
            end
        end
    end

    assign vga_r_o       = r_pix.r;
    assign vga_g_o       = r_pix.g;
    assign vga_b_o       = r_pix.b;
    assign hsync_o       = r_hsync;
    assign vsync_o       = r_vsync;
    assign de_o          = r_de;
    assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_vga_scan_out.sv
// Self-checking bench for vga_scan_out on a reduced raster (32x19) so whole
// frames fit in a short run; expectations come from a position-based model.
module tb_vga_scan_out;

    localparam int HA = 20, HF = 3, HS = 4, HB = 5;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam bit POL = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_ce_i = 1'b0;
    logic [9:0]  raddr_h_o;
    logic [8:0]  raddr_v_o;
    logic [23:0] vga_rdata_i;
    logic [7:0]  vga_r_o, vga_g_o, vga_b_o;
    logic        hsync_o, vsync_o, de_o, frame_start_o;
    logic [23:0] salt = 24'h0;

    always #5 clk = ~clk;

    // Frame memory stand-in: pixel value encodes its own address.
    assign vga_rdata_i = {raddr_v_o[7:0], raddr_h_o[7:0], 8'hA5} ^ salt;

    vga_scan_out #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (POL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_ce_i      (pix_ce_i),
        .raddr_h_o     (raddr_h_o),
        .raddr_v_o     (raddr_v_o),
        .vga_rdata_i   (vga_rdata_i),
        .vga_r_o       (vga_r_o),
        .vga_g_o       (vga_g_o),
        .vga_b_o       (vga_b_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .de_o          (de_o),
        .frame_start_o (frame_start_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: raster position and the outputs the last tick should produce.
    int          mh, mv;
    logic [23:0] e_rgb;
    logic        e_de, e_hs, e_vs, e_fs;

    function automatic logic [23:0] pix_at(input int h, input int v);
        return {v[7:0], h[7:0], 8'hA5} ^ salt;
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0;
        e_rgb = 24'h0; e_de = 1'b0; e_fs = 1'b0;
        e_hs = ~POL; e_vs = ~POL;
    endtask

    task automatic model_tick();
        bit vis;
        vis   = (mh < HA) && (mv < VA);
        e_de  = vis;
        e_rgb = vis ? pix_at(mh, mv) : 24'h0;
        e_hs  = (mh >= HA + HF && mh < HA + HF + HS) ? POL : ~POL;
        e_vs  = (mv >= VA + VF && mv < VA + VF + VS) ? POL : ~POL;
        e_fs  = (mh == 0) && (mv == 0);
        mh++;
        if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
        end
    endtask

    function automatic logic [18:0] exp_addr();
        bit vis;
        vis = (mh < HA) && (mv < VA);
        return vis ? {10'(mh), 9'(mv)} : 19'h0;
    endfunction

    // One clk with per-cycle comparison against the model.
    task automatic cycle(input bit ce, input bit rst);
        pix_ce_i = ce;
        rst_n    = rst;
        @(posedge clk);
        #1;
        if (!rst)    model_reset();
        else if (ce) model_tick();
        else         e_fs = 1'b0;
        check("outputs", {vga_r_o, vga_g_o, vga_b_o, de_o, hsync_o, vsync_o, frame_start_o},
              {e_rgb, e_de, e_hs, e_vs, e_fs});
        check("raddr", {raddr_h_o, raddr_v_o}, exp_addr());
    endtask

    typedef struct {
        bit          rst;
        bit          ce;
        logic [23:0] rgb;
        bit          de, hs, vs, fs;
        logic [9:0]  rh;
        logic [8:0]  rv;
    } vec_t;

    vec_t vecs[11];

    logic [23:0] full_q[$];
    logic [23:0] half_q[$];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset hold, stall, first ticks and a re-reset.
        for (int i = 0; i < 5; i++)
            vecs[i] = '{1'b0, 1'b1, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0};
        vecs[5]  = '{1'b1, 1'b0, 24'h0,     1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0};
        vecs[6]  = '{1'b1, 1'b1, 24'h0000A5, 1'b1, 1'b1, 1'b1, 1'b1, 10'd1, 9'd0};
        vecs[7]  = '{1'b1, 1'b0, 24'h0000A5, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1, 9'd0};
        vecs[8]  = '{1'b1, 1'b1, 24'h0001A5, 1'b1, 1'b1, 1'b1, 1'b0, 10'd2, 9'd0};
        vecs[9]  = '{1'b0, 1'b1, 24'h0,     1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0};
        vecs[10] = '{1'b1, 1'b1, 24'h0000A5, 1'b1, 1'b1, 1'b1, 1'b1, 10'd1, 9'd0};

        for (int i = 0; i < 11; i++) begin
            pix_ce_i = vecs[i].ce;
            rst_n    = vecs[i].rst;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out", i),
                  {vga_r_o, vga_g_o, vga_b_o, de_o, hsync_o, vsync_o, frame_start_o},
                  {vecs[i].rgb, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].fs});
            check($sformatf("vec%0d_raddr", i), {raddr_h_o, raddr_v_o}, {vecs[i].rh, vecs[i].rv});
        end

        // Full-rate run over two frames plus a line, measuring the raster.
        begin : full_rate
            int t_de_rise[$], t_hs_fall[$], t_vs_fall[$], t_fs[$];
            int de_len[$], hs_len[$], vs_len[$];
            int de_run = 0, hs_run = 0, vs_run = 0, lines = -1, blank_bad = 0, bad = 0;
            bit p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1;
            logic [23:0] line3 = 24'hFFFFFF;
            salt = 24'h0;
            cycle(1'b1, 1'b0);
            for (int n = 0; n < 2 * FRAME + HT; n++) begin
                cycle(1'b1, 1'b1);
                if (frame_start_o) begin t_fs.push_back(n); lines = 0; end
                if (de_o && !p_de) begin
                    t_de_rise.push_back(n);
                    if (lines == 3) line3 = {vga_r_o, vga_g_o, vga_b_o};
                    if (lines >= 0) lines++;
                end
                if (de_o) de_run++;
                else if (p_de) begin de_len.push_back(de_run); de_run = 0; end
                if (!hsync_o) hs_run++;
                if (!hsync_o && p_hs) t_hs_fall.push_back(n);
                if (hsync_o && !p_hs) begin hs_len.push_back(hs_run); hs_run = 0; end
                if (!vsync_o) vs_run++;
                if (!vsync_o && p_vs) t_vs_fall.push_back(n);
                if (vsync_o && !p_vs) begin vs_len.push_back(vs_run); vs_run = 0; end
                if (!de_o && {vga_r_o, vga_g_o, vga_b_o} != 24'h0) blank_bad++;
                if (de_o && t_fs.size() == 1) full_q.push_back({vga_r_o, vga_g_o, vga_b_o});
                p_de = de_o; p_hs = hsync_o; p_vs = vsync_o;
            end
            foreach (de_len[i]) if (de_len[i] != HA) bad++;
            check("de_run_len_bad", bad, 0);
            check("de_run_count", de_len.size(), 2 * VA + 1);
            bad = 0;
            foreach (hs_len[i]) if (hs_len[i] != HS) bad++;
            check("hs_len_bad", bad, 0);
            check("hs_offset", (t_hs_fall.size() > 0 && t_de_rise.size() > 0) ?
                  t_hs_fall[0] - t_de_rise[0] : -1, HA + HF);
            check("hs_period", (t_hs_fall.size() > 1) ? t_hs_fall[1] - t_hs_fall[0] : -1, HT);
            check("vs_offset", (t_vs_fall.size() > 0 && t_fs.size() > 0) ?
                  t_vs_fall[0] - t_fs[0] : -1, (VA + VF) * HT);
            check("vs_len", (vs_len.size() > 0) ? vs_len[0] : -1, VS * HT);
            check("frame_period", (t_fs.size() > 1) ? t_fs[1] - t_fs[0] : -1, FRAME);
            check("line3_first_pix", line3, 24'h0300A5);
            check("rgb_in_blank", blank_bad, 0);
            check("frame_pix_count", full_q.size(), HA * VA);
        end

        // Half-rate run: same pixel sequence, one-clk frame_start per frame.
        begin : half_rate
            int fs_cnt = 0, diff = 0;
            cycle(1'b1, 1'b0);
            for (int n = 0; n < 4 * FRAME; n++) begin
                cycle(n % 2 == 0, 1'b1);
                if (frame_start_o) fs_cnt++;
                if (n % 2 == 0 && de_o && fs_cnt == 1) half_q.push_back({vga_r_o, vga_g_o, vga_b_o});
            end
            check("half_fs_count", fs_cnt, 2);
            check("half_pix_count", half_q.size(), full_q.size());
            foreach (half_q[i]) if (i < full_q.size() && half_q[i] != full_q[i]) diff++;
            check("half_pix_seq", diff, 0);
        end

        // Random pixel-enable and memory contents against the model.
        cycle(1'b1, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) salt = 24'($urandom);
            cycle($urandom_range(0, 3) != 0, 1'b1);
        end

        // Double wrap at the last position of the frame.
        salt = 24'h0;
        cycle(1'b1, 1'b0);
        for (int n = 0; n < FRAME && !(mh == HT - 1 && mv == VT - 1); n++) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        check("wrap_raddr", {raddr_h_o, raddr_v_o}, 19'h0);
        check("wrap_de", de_o, 1'b0);
        cycle(1'b1, 1'b1);
        check("wrap_fs", frame_start_o, 1'b1);
        check("wrap_first_pix", {de_o, vga_r_o, vga_g_o, vga_b_o}, {1'b1, 24'h0000A5});

        // Reset in the middle of a frame restarts at (0,0).
        for (int n = 0; n < FRAME && !(mh == HA / 2 && mv == VA / 2 + 1); n++) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        check("midrst_out", {vga_r_o, vga_g_o, vga_b_o, de_o, hsync_o, vsync_o, frame_start_o},
              {24'h0, 1'b0, 1'b1, 1'b1, 1'b0});
        check("midrst_raddr", {raddr_h_o, raddr_v_o}, 19'h0);
        cycle(1'b1, 1'b1);
        check("midrst_fs", {frame_start_o, vga_r_o, vga_g_o, vga_b_o}, {1'b1, 24'h0000A5});
        check("midrst_next_raddr", {raddr_h_o, raddr_v_o}, {10'd1, 9'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
